// File: rtl/sample_serializer.sv
// sample_serializer: pops SAMPLE_WIDTH-bit records from a show-ahead FIFO and
// streams them to the host one byte per data_rdy/data_ack handshake, with
// runtime byte order, optional periodic sync markers and a sent-record count.
module sample_serializer #(
  parameter int         SAMPLE_WIDTH  = 48,
  parameter int         SYNC_INTERVAL = 1024,
  parameter int         SYNC_LEN      = 2,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_rdy,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_ack,
  output logic                    data_rdy,
  output logic [7:0]              data,
  input  logic                    data_ack,
  input  logic                    msb_first,
  input  logic                    sync_en,
  output logic [31:0]             samples_sent,
  output logic                    busy
);

  localparam int NBYTES = (SAMPLE_WIDTH + 7) / 8;
  localparam int PADW   = NBYTES * 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [2:0]    SYNC_LAST = 3'(SYNC_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST  = (SYNC_INTERVAL > 0) ? CW'(SYNC_INTERVAL - 1) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PADW-1:0] rec_q, rec_d;
  logic            msb_q, msb_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      sidx_q, sidx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sent_q, sent_d;

  logic [IW-1:0]   byte_sel;
  logic [PADW-1:0] rec_shifted;

  // Handshake outputs and the byte currently presented to the host
  always_comb begin
    sample_ack   = (state_q == IDLE) && sample_rdy && !reset;
    data_rdy     = (state_q == SYNC) || (state_q == SEND);
    busy         = (state_q != IDLE);
    samples_sent = sent_q;
    byte_sel     = msb_q ? (LAST_IDX - idx_q) : idx_q;
    rec_shifted  = rec_q >> {byte_sel, 3'b000};
    case (state_q)
      SYNC:    data = SYNC_BYTE;
      SEND:    data = rec_shifted[7:0];
      default: data = '0;
    endcase
  end

  // Next-state logic: record latch, marker/byte sequencing, counters
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
    sidx_d  = sidx_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (sample_rdy) begin
          rec_d  = PADW'(sample);
          msb_d  = msb_first;
          idx_d  = '0;
          sidx_d = '0;
          if ((cnt_q == '0) && sync_en && (SYNC_INTERVAL > 0)) state_d = SYNC;
          else                                                 state_d = SEND;
        end
      end
      SYNC: begin
        if (data_ack) begin
          if (sidx_q == SYNC_LAST) begin
            state_d = SEND;
            idx_d   = '0;
          end else begin
            sidx_d = sidx_q + 3'd1;
          end
        end
      end
      SEND: begin
        if (data_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            sent_d  = sent_q + 32'd1;
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rec_q   <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
      sidx_q  <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      msb_q   <= msb_d;
      idx_q   <= idx_d;
      sidx_q  <= sidx_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
    end
  end

endmodule
